// File: rtl/ts_pkg.sv
// Shared constants, register offsets, channel state encoding and TS byte builder
// for the TS stream generator.
package ts_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'h47;

  localparam logic [7:0] REG_CTRL        = 8'h00;
  localparam logic [3:0] REG_PID         = 4'h0;
  localparam logic [3:0] REG_LOSS_PERIOD = 4'h4;
  localparam logic [3:0] REG_GAP         = 4'h8;
  localparam logic [3:0] REG_PKT_COUNT   = 4'hC;
  localparam int unsigned CH_STRIDE      = 16;

  localparam int unsigned PID_W  = 13;
  localparam int unsigned GAP_W  = 8;
  localparam int unsigned LOSS_W = 16;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned CC_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PKT  = 2'd1,
    ST_GAP  = 2'd2
  } ch_state_e;

  // Byte at position idx of a packet carrying the given PID and continuity counter.
  function automatic logic [7:0] ts_byte(input logic [7:0] idx,
                                         input logic [PID_W-1:0] pid,
                                         input logic [CC_W-1:0] cc);
    case (idx)
      8'd0:    return SYNC_BYTE;
      8'd1:    return {3'b000, pid[12:8]};
      8'd2:    return pid[7:0];
      8'd3:    return {4'b0001, cc};
      default: return idx;
    endcase
  endfunction

endpackage

// File: rtl/ts_gen_channel.sv
// One TS output channel: packet/gap sequencing, continuity counter, emitted-packet count.
// Loss injection (slot counter + drop) is built only with TS_GEN_LOSS_INJECT_EN defined.
module ts_gen_channel
  import ts_pkg::*;
#(
  parameter int unsigned PKT_LEN = 188
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  input  logic [PID_W-1:0]  pid,
  input  logic [GAP_W-1:0]  gap,
`ifdef TS_GEN_LOSS_INJECT_EN
  input  logic [LOSS_W-1:0] loss_period,
`endif
  output logic [7:0]        byte_data,
  output logic              byte_valid,
  output logic              sop,
  output logic [CNT_W-1:0]  pkt_count
);

  localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);

  ch_state_e          state;
  logic [7:0]         idx;
  logic [GAP_W-1:0]   gap_cnt;
  logic [GAP_W-1:0]   gap_l;
  logic [CC_W-1:0]    cc;
  logic [PID_W-1:0]   pid_l;
  logic               drop_l;
`ifdef TS_GEN_LOSS_INJECT_EN
  logic [LOSS_W-1:0]  slot_cnt;
`endif

  logic               slot_start;
  logic               drop_now;
  logic               cur_drop;
  logic               last;
  logic [7:0]         emit_idx;
  logic [PID_W-1:0]   emit_pid;

  // A slot starts on the edge that emits byte 0; its config is sampled live on that edge.
  always_comb begin
    slot_start = run && ((state == ST_IDLE) || ((state == ST_PKT) && (idx == 8'd0)));
    emit_idx   = slot_start ? 8'd0 : idx;
    emit_pid   = slot_start ? pid : pid_l;
`ifdef TS_GEN_LOSS_INJECT_EN
    drop_now   = (loss_period != '0) && (slot_cnt == loss_period - LOSS_W'(1));
`else
    drop_now   = 1'b0;
`endif
    cur_drop   = slot_start ? drop_now : drop_l;
    last       = (emit_idx == LAST_IDX);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      gap_cnt    <= '0;
      gap_l      <= '0;
      cc         <= '0;
      pid_l      <= '0;
      drop_l     <= 1'b0;
      pkt_count  <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      sop        <= 1'b0;
`ifdef TS_GEN_LOSS_INJECT_EN
      slot_cnt   <= '0;
`endif
    end else begin
      byte_data  <= 8'h00;
      byte_valid <= 1'b0;
      sop        <= 1'b0;
      case (state)
        ST_GAP: begin
          if (!run) begin
            state <= ST_IDLE;
          end else if (gap_cnt <= GAP_W'(1)) begin
            state <= ST_PKT;
            idx   <= '0;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: begin
          if (slot_start || ((state == ST_PKT) && (idx != 8'd0))) begin
            state <= ST_PKT;
            if (slot_start) begin
              pid_l  <= pid;
              gap_l  <= gap;
              drop_l <= drop_now;
            end
            byte_valid <= !cur_drop;
            sop        <= slot_start && !cur_drop;
            byte_data  <= cur_drop ? 8'h00 : ts_byte(emit_idx, emit_pid, cc);
            if (last) begin
              idx <= '0;
              cc  <= cc + CC_W'(1);
              if (!cur_drop) pkt_count <= pkt_count + CNT_W'(1);
`ifdef TS_GEN_LOSS_INJECT_EN
              if ((loss_period == '0) || (slot_cnt >= loss_period - LOSS_W'(1)))
                slot_cnt <= '0;
              else
                slot_cnt <= slot_cnt + LOSS_W'(1);
`endif
              if (!run) begin
                state <= ST_IDLE;
              end else if (gap_l != '0) begin
                state   <= ST_GAP;
                gap_cnt <= gap_l;
              end
            end else begin
              idx <= emit_idx + 8'd1;
            end
          end else begin
            state <= ST_IDLE;
            idx   <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/ts_stream_gen.sv
// Multi-channel TS test-stream generator with memory-mapped control registers.
// LOSS_PERIOD registers exist only with TS_GEN_LOSS_INJECT_EN defined; otherwise they read 0.
module ts_stream_gen
  import ts_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned PKT_LEN = 188
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            mm_addr,
  input  logic [31:0]           mm_wdata,
  input  logic                  mm_write_en,
  input  logic                  mm_read_en,
  output logic [31:0]           mm_rdata,
  output logic [NUM_CH*8-1:0]   byte_data,
  output logic [NUM_CH-1:0]     byte_valid,
  output logic [NUM_CH-1:0]     sop
);

  logic                 run;
  logic [PID_W-1:0]     pid_r  [NUM_CH];
  logic [GAP_W-1:0]     gap_r  [NUM_CH];
`ifdef TS_GEN_LOSS_INJECT_EN
  logic [LOSS_W-1:0]    loss_r [NUM_CH];
`endif
  logic [CNT_W-1:0]     cnt_w  [NUM_CH];
  logic [31:0]          rd_val;
  logic                 unused_wdata;

  assign unused_wdata = ^mm_wdata;

  function automatic logic ch_hit(input logic [7:0] addr, input int unsigned c);
    return {addr[7:4], 4'h0} == 8'(CH_STRIDE * (c + 1));
  endfunction

  // Register writes; read-only and unmapped addresses fall through untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run <= 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        pid_r[c]  <= '0;
        gap_r[c]  <= '0;
`ifdef TS_GEN_LOSS_INJECT_EN
        loss_r[c] <= '0;
`endif
      end
    end else if (mm_write_en) begin
      if (mm_addr == REG_CTRL) run <= mm_wdata[0];
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (ch_hit(mm_addr, c)) begin
          case (mm_addr[3:0])
            REG_PID:         pid_r[c]  <= mm_wdata[PID_W-1:0];
            REG_GAP:         gap_r[c]  <= mm_wdata[GAP_W-1:0];
`ifdef TS_GEN_LOSS_INJECT_EN
            REG_LOSS_PERIOD: loss_r[c] <= mm_wdata[LOSS_W-1:0];
`endif
            default: ;
          endcase
        end
      end
    end
  end

  // Read mux sees pre-write register values, so a same-cycle write returns old data.
  always_comb begin
    rd_val = '0;
    if (mm_addr == REG_CTRL) rd_val = {31'd0, run};
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (ch_hit(mm_addr, c)) begin
        case (mm_addr[3:0])
          REG_PID:         rd_val = 32'(pid_r[c]);
          REG_GAP:         rd_val = 32'(gap_r[c]);
`ifdef TS_GEN_LOSS_INJECT_EN
          REG_LOSS_PERIOD: rd_val = 32'(loss_r[c]);
`endif
          REG_PKT_COUNT:   rd_val = cnt_w[c];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mm_rdata <= '0;
    else          mm_rdata <= mm_read_en ? rd_val : '0;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ts_gen_channel #(.PKT_LEN(PKT_LEN)) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .run        (run),
      .pid        (pid_r[c]),
      .gap        (gap_r[c]),
`ifdef TS_GEN_LOSS_INJECT_EN
      .loss_period(loss_r[c]),
`endif
      .byte_data  (byte_data[8*c +: 8]),
      .byte_valid (byte_valid[c]),
      .sop        (sop[c]),
      .pkt_count  (cnt_w[c])
    );
  end

endmodule

// File: tb/tb_ts_stream_gen.sv
// Self-checking bench for ts_stream_gen: register vector table plus a per-cycle stream scoreboard.
module tb_ts_stream_gen;

  localparam int NCH  = 4;
  localparam int PLEN = 188;
`ifdef TS_GEN_LOSS_INJECT_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif

  localparam int OP_W  = 0;
  localparam int OP_R  = 1;
  localparam int OP_RW = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [7:0]        mm_addr;
  logic [31:0]       mm_wdata;
  logic              mm_write_en;
  logic              mm_read_en;
  logic [31:0]       mm_rdata;
  logic [NCH*8-1:0]  byte_data;
  logic [NCH-1:0]    byte_valid;
  logic [NCH-1:0]    sop;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          op;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } reg_vec_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  valid;
    logic [3:0]  sop;
  } cyc_t;

  reg_vec_t vecs [64];
  int       nv = 0;
  cyc_t     sb [$];

  ts_stream_gen #(.NUM_CH(NCH), .PKT_LEN(PLEN)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mm_addr    (mm_addr),
    .mm_wdata   (mm_wdata),
    .mm_write_en(mm_write_en),
    .mm_read_en (mm_read_en),
    .mm_rdata   (mm_rdata),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .sop        (sop)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic add(input int op, input logic [7:0] a, input logic [31:0] w,
                     input logic [31:0] x, input string n);
    vecs[nv] = '{op, a, w, x, n};
    nv++;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] w);
    @(negedge clk);
    mm_addr = a; mm_wdata = w; mm_write_en = 1'b1;
    @(negedge clk);
    mm_write_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    mm_addr = a; mm_read_en = 1'b1;
    @(negedge clk);
    mm_read_en = 1'b0;
    d = mm_rdata;
  endtask

  task automatic rw(input logic [7:0] a, input logic [31:0] w, output logic [31:0] d);
    @(negedge clk);
    mm_addr = a; mm_wdata = w; mm_read_en = 1'b1; mm_write_en = 1'b1;
    @(negedge clk);
    mm_read_en = 1'b0; mm_write_en = 1'b0;
    d = mm_rdata;
  endtask

  initial begin
    logic [31:0] d;
    logic [12:0] pid_cfg [NCH];
    int          gap_cfg [NCH];
    int          lp_cfg  [NCH];
    int          exp_cnt [NCH];
    logic [7:0]  hdr     [5];
    cyc_t        e;
    int          kclr;
    int          len;
    int          bad;

    reset_n = 1'b0; mm_addr = '0; mm_wdata = '0; mm_write_en = 1'b0; mm_read_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_byte_data", byte_data, 32'h0);
    check("rst_byte_valid", 32'(byte_valid), 32'h0);
    check("rst_sop", 32'(sop), 32'h0);
    check("rst_rdata", mm_rdata, 32'h0);
    reset_n = 1'b1;

    // Register vectors: reset values, field masking, read-only/unmapped, read-during-write.
    add(OP_R,  8'h00, 0, 32'h0, "ctrl_rst");
    add(OP_R,  8'h10, 0, 32'h0, "pid0_rst");
    add(OP_R,  8'h1C, 0, 32'h0, "cnt0_rst");
    add(OP_R,  8'h34, 0, 32'h0, "lp2_rst");
    add(OP_W,  8'h10, 32'hFFFF_FFFF, 0, "");
    add(OP_R,  8'h10, 0, 32'h1FFF, "pid0_mask");
    add(OP_W,  8'h28, 32'h1FF, 0, "");
    add(OP_R,  8'h28, 0, 32'hFF, "gap1_mask");
    add(OP_W,  8'h34, 32'h12345, 0, "");
    add(OP_R,  8'h34, 0, LP_EN ? 32'h2345 : 32'h0, "lp2_wr");
    add(OP_W,  8'h1C, 32'h5, 0, "");
    add(OP_R,  8'h1C, 0, 32'h0, "cnt0_read_only");
    add(OP_W,  8'h50, 32'h77, 0, "");
    add(OP_R,  8'h50, 0, 32'h0, "unmapped_ch4");
    add(OP_R,  8'h04, 0, 32'h0, "unmapped_low");
    add(OP_W,  8'h40, 32'hAA, 0, "");
    add(OP_RW, 8'h40, 32'h55, 32'hAA, "rw_same_old");
    add(OP_R,  8'h40, 0, 32'h55, "pid3_new");
    add(OP_W,  8'h42, 32'h1234, 0, "");
    add(OP_R,  8'h42, 0, 32'h0, "unaligned");
    add(OP_R,  8'h40, 0, 32'h55, "pid3_keep");
    add(OP_W,  8'h00, 32'hFFFF_FFFE, 0, "");
    add(OP_R,  8'h00, 0, 32'h0, "ctrl_bit0");
    add(OP_W,  8'h10, 32'h100, 0, "");
    add(OP_W,  8'h20, 32'hABC, 0, "");
    add(OP_W,  8'h30, 32'h1FFF, 0, "");
    add(OP_W,  8'h40, 32'h055, 0, "");
    add(OP_W,  8'h28, 32'h5, 0, "");
    add(OP_W,  8'h48, 32'h2, 0, "");
    add(OP_W,  8'h34, 32'h3, 0, "");
    add(OP_R,  8'h30, 0, 32'h1FFF, "pid2_cfg");
    add(OP_R,  8'h48, 0, 32'h2, "gap3_cfg");

    for (int t = 0; t < nv; t++) begin
      case (vecs[t].op)
        OP_W: wr(vecs[t].addr, vecs[t].wdata);
        OP_R: begin
          rd(vecs[t].addr, d);
          check(vecs[t].name, d, vecs[t].exp);
        end
        default: begin
          rw(vecs[t].addr, vecs[t].wdata, d);
          check(vecs[t].name, d, vecs[t].exp);
        end
      endcase
    end

    // Stream scoreboard: expected per-cycle outputs of all channels from a closed-form slot model.
    pid_cfg = '{13'h100, 13'hABC, 13'h1FFF, 13'h055};
    gap_cfg = '{0, 5, 0, 2};
    lp_cfg  = '{0, 0, 3, 0};
    exp_cnt = '{0, 0, 0, 0};
    kclr = 16 * PLEN + 51;
    len  = 3500;
    for (int i = 0; i < len; i++) begin
      e = '0;
      for (int c = 0; c < NCH; c++) begin
        int p, j, k;
        logic [12:0] pd;
        logic [7:0]  b;
        bit drop;
        p  = PLEN + gap_cfg[c];
        j  = i / p;
        k  = i % p;
        pd = (c == 0 && j > 0) ? 13'h0AB : pid_cfg[c];
        drop = LP_EN && (lp_cfg[c] != 0) && ((j % lp_cfg[c]) == lp_cfg[c] - 1);
        if (k < PLEN && j * p < kclr && !drop) begin
          case (k)
            0:       b = 8'h47;
            1:       b = {3'b000, pd[12:8]};
            2:       b = pd[7:0];
            3:       b = {4'h1, 4'(j)};
            default: b = 8'(k);
          endcase
          e.data[8*c +: 8] = b;
          e.valid[c] = 1'b1;
          e.sop[c]   = (k == 0);
          if (k == 0) exp_cnt[c]++;
        end
      end
      sb.push_back(e);
    end

    wr(8'h00, 32'h1);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (byte_data !== e.data || byte_valid !== e.valid || sop !== e.sop) begin
        errors++;
        $display("FAIL stream[%0d] actual data=%h valid=%b sop=%b expected data=%h valid=%b sop=%b",
                 i, byte_data, byte_valid, sop, e.data, e.valid, e.sop);
      end
      mm_write_en = 1'b0;
      if (i == 0) begin
        mm_addr = 8'h10; mm_wdata = 32'h0AB; mm_write_en = 1'b1;
      end
      if (i == kclr - 2) begin
        mm_addr = 8'h00; mm_wdata = 32'h0; mm_write_en = 1'b1;
      end
    end
    mm_write_en = 1'b0;

    for (int c = 0; c < NCH; c++) begin
      rd(8'(16 * (c + 1) + 12), d);
      check($sformatf("pkt_count%0d", c), d, 32'(exp_cnt[c]));
    end
    rd(8'h34, d);
    check("lp2_final", d, LP_EN ? 32'h3 : 32'h0);

    // Asynchronous reset in the middle of a packet.
    wr(8'h10, 32'h100);
    wr(8'h00, 32'h1);
    for (int i = 0; i <= 50; i++) @(negedge clk);
    check("pre_rst_byte50", {23'd0, byte_valid[0], byte_data[7:0]}, {23'd0, 1'b1, 8'd50});
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_data", byte_data, 32'h0);
    check("async_rst_valid", 32'(byte_valid), 32'h0);
    check("async_rst_sop", 32'(sop), 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (byte_data != '0 || byte_valid != '0 || sop != '0) bad++;
    end
    check("idle_after_rst", 32'(bad), 32'h0);
    rd(8'h00, d);
    check("ctrl_after_rst", d, 32'h0);
    rd(8'h10, d);
    check("pid0_after_rst", d, 32'h0);
    rd(8'h1C, d);
    check("cnt0_after_rst", d, 32'h0);

    // Fresh start: CC restarts at 0 and no partial packet resumes.
    hdr = '{8'h47, 8'h01, 8'h00, 8'h10, 8'h04};
    wr(8'h10, 32'h100);
    wr(8'h00, 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("restart_byte%0d", i),
            {22'd0, sop[0], byte_valid[0], byte_data[7:0]},
            {22'd0, (i == 0), 1'b1, hdr[i]});
    end
    wr(8'h00, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
